// File: rtl/time_preset_loader.sv
// Purpose: collects a 9-byte time/calendar record, validates it, then presets the time counter.
// Latency: load (or reject) pulse is high for one cycle, 2 edges after the last byte is accepted.
// Backpressure: wr_ready_o is high only while receiving. It drops for the check/load/error cycles and while abort_i is high.
module time_preset_loader (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_valid_i,
    input  logic [7:0]  wr_data_i,
    output logic        wr_ready_o,
    input  logic        abort_i,
    output logic        enable_o,
    output logic        en_preset_o,
    output logic [5:0]  init_sec_o,
    output logic [5:0]  init_min_o,
    output logic [5:0]  init_hour_o,
    output logic [1:0]  init_mode_o,
    output logic [2:0]  init_day_of_week_o,
    output logic [4:0]  init_day_of_month_o,
    output logic [3:0]  init_month_o,
    output logic [11:0] init_year_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [1:0] RECV  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    logic [1:0]  state_q;
    logic [3:0]  idx_q;
    logic        accept;
    logic        rec_ok;
    logic [4:0]  max_day;

    // Staged record fields, already truncated to their field widths
    logic [5:0]  st_sec;
    logic [5:0]  st_min;
    logic [5:0]  st_hour;
    logic [1:0]  st_mode;
    logic [2:0]  st_dow;
    logic [4:0]  st_dom;
    logic [3:0]  st_month;
    logic [11:0] st_year;

    // Ready is also gated by rst_i so that it reads 0 for the whole reset window
    assign wr_ready_o  = !rst_i && (state_q == RECV) && !abort_i;
    assign accept      = wr_valid_i && wr_ready_o;
    assign enable_o    = (state_q == LOAD);
    assign en_preset_o = (state_q == LOAD);
    assign err_o       = (state_q == ERR);
    assign busy_o      = (idx_q != 4'd0) || (state_q != RECV);

    // Month length, with the Gregorian century exception limited to 2100
    always_comb begin
        max_day = 5'd31;
        case (st_month)
            4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
            4'd2: max_day = ((st_year[1:0] == 2'b00) && (st_year != 12'd2100)) ? 5'd29 : 5'd28;
            default: max_day = 5'd31;
        endcase
    end

    // Validity of the whole staged record
    always_comb begin
        logic time_ok;
        logic hour_ok;
        logic cal_ok;
        time_ok = (st_sec <= 6'd59) && (st_min <= 6'd59);
        if (st_mode[0])
            hour_ok = (st_hour >= 6'd1) && (st_hour <= 6'd12);
        else
            hour_ok = (st_hour <= 6'd23) && !st_mode[1];
        cal_ok  = (st_dow != 3'd0)
               && (st_month >= 4'd1) && (st_month <= 4'd12)
               && (st_dom >= 5'd1) && (st_dom <= max_day);
        rec_ok  = time_ok && hour_ok && cal_ok;
    end

    // Sequencer: byte index while receiving, then one check cycle and one load/error cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RECV;
            idx_q   <= 4'd0;
        end else begin
            case (state_q)
                RECV: begin
                    if (abort_i) begin
                        idx_q <= 4'd0;
                    end else if (accept) begin
                        if (idx_q == 4'd8) begin
                            idx_q   <= 4'd0;
                            state_q <= CHECK;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                CHECK:   state_q <= rec_ok ? LOAD : ERR;
                default: begin
                    state_q <= RECV;
                    idx_q   <= 4'd0;
                end
            endcase
        end
    end

    // Staging: each accepted byte lands in the field selected by the index
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_sec   <= '0;
            st_min   <= '0;
            st_hour  <= '0;
            st_mode  <= '0;
            st_dow   <= '0;
            st_dom   <= '0;
            st_month <= '0;
            st_year  <= '0;
        end else if (accept) begin
            case (idx_q)
                4'd0: st_sec         <= wr_data_i[5:0];
                4'd1: st_min         <= wr_data_i[5:0];
                4'd2: st_hour        <= wr_data_i[5:0];
                4'd3: st_mode        <= wr_data_i[1:0];
                4'd4: st_dow         <= wr_data_i[2:0];
                4'd5: st_dom         <= wr_data_i[4:0];
                4'd6: st_month       <= wr_data_i[3:0];
                4'd7: st_year[7:0]   <= wr_data_i;
                4'd8: st_year[11:8]  <= wr_data_i[3:0];
                default: ;
            endcase
        end
    end

    // Preset values: copied from staging only when a checked record is good
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_sec_o          <= 6'd0;
            init_min_o          <= 6'd0;
            init_hour_o         <= 6'd0;
            init_mode_o         <= 2'b00;
            init_day_of_week_o  <= 3'd1;
            init_day_of_month_o <= 5'd1;
            init_month_o        <= 4'd1;
            init_year_o         <= 12'd2000;
        end else if ((state_q == CHECK) && rec_ok) begin
            init_sec_o          <= st_sec;
            init_min_o          <= st_min;
            init_hour_o         <= st_hour;
            init_mode_o         <= st_mode;
            init_day_of_week_o  <= st_dow;
            init_day_of_month_o <= st_dom;
            init_month_o        <= st_month;
            init_year_o         <= st_year;
        end
    end

endmodule

// File: tb/tb_time_preset_loader.sv
// Bench for time_preset_loader: directed records plus randomized records,
// checked every cycle against a record-level reference model.
module tb_time_preset_loader;

    typedef struct packed {
        int sec; int min; int hour; int mode;
        int dow; int dom; int mon;  int year;
    } rec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [7:0]  wr_data_i = 8'd0;
    logic        abort_i = 1'b0;
    logic        wr_ready_o, enable_o, en_preset_o, busy_o, err_o;
    logic [5:0]  init_sec_o, init_min_o, init_hour_o;
    logic [1:0]  init_mode_o;
    logic [2:0]  init_day_of_week_o;
    logic [4:0]  init_day_of_month_o;
    logic [3:0]  init_month_o;
    logic [11:0] init_year_o;

    time_preset_loader dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
        .abort_i(abort_i), .enable_o(enable_o), .en_preset_o(en_preset_o),
        .init_sec_o(init_sec_o), .init_min_o(init_min_o), .init_hour_o(init_hour_o),
        .init_mode_o(init_mode_o), .init_day_of_week_o(init_day_of_week_o),
        .init_day_of_month_o(init_day_of_month_o), .init_month_o(init_month_o),
        .init_year_o(init_year_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int n_load = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic rec_t decode(input logic [7:0] b [9]);
        rec_t r;
        r.sec  = int'(b[0]) % 64;
        r.min  = int'(b[1]) % 64;
        r.hour = int'(b[2]) % 64;
        r.mode = int'(b[3]) % 4;
        r.dow  = int'(b[4]) % 8;
        r.dom  = int'(b[5]) % 32;
        r.mon  = int'(b[6]) % 16;
        r.year = int'(b[7]) + 256 * (int'(b[8]) % 16);
        return r;
    endfunction

    function automatic bit rec_valid(input rec_t r);
        int dim [13];
        int md;
        bit hour_ok;
        dim = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (r.mon < 1 || r.mon > 12) return 1'b0;
        md = dim[r.mon];
        if (r.mon == 2 && (r.year % 4 == 0) && r.year != 2100) md = 29;
        if (r.mode % 2 == 1) hour_ok = (r.hour >= 1 && r.hour <= 12);
        else                 hour_ok = (r.hour <= 23 && r.mode == 0);
        return (r.sec <= 59) && (r.min <= 59) && hour_ok
            && (r.dow >= 1 && r.dow <= 7) && (r.dom >= 1 && r.dom <= md);
    endfunction

    logic [7:0] m_b [9];
    int   m_cnt;      // bytes collected in the current record
    int   m_since;    // 0 while collecting; 1 = cycle after the 9th byte; 2 = pulse cycle
    bit   m_ok;
    rec_t m_init;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cnt   <= 0;
            m_since <= 0;
            m_ok    <= 1'b0;
            m_init  <= '{sec:0, min:0, hour:0, mode:0, dow:1, dom:1, mon:1, year:2000};
        end else if (m_since == 0) begin
            if (abort_i) begin
                m_cnt <= 0;
            end else if (wr_valid_i) begin
                m_b[m_cnt] <= wr_data_i;
                if (m_cnt == 8) begin
                    m_cnt   <= 0;
                    m_since <= 1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (m_since == 1) begin
            m_since <= 2;
            m_ok    <= rec_valid(decode(m_b));
            if (rec_valid(decode(m_b))) m_init <= decode(m_b);
        end else begin
            m_since <= 0;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("wr_ready",    int'(wr_ready_o),  int'(!rst_i && m_since == 0 && !abort_i));
            check("enable",      int'(enable_o),    int'(!rst_i && m_since == 2 && m_ok));
            check("en_preset",   int'(en_preset_o), int'(!rst_i && m_since == 2 && m_ok));
            check("err",         int'(err_o),       int'(!rst_i && m_since == 2 && !m_ok));
            check("busy",        int'(busy_o),      int'(!rst_i && (m_cnt != 0 || m_since != 0)));
            check("init_sec",    int'(init_sec_o),          m_init.sec);
            check("init_min",    int'(init_min_o),          m_init.min);
            check("init_hour",   int'(init_hour_o),         m_init.hour);
            check("init_mode",   int'(init_mode_o),         m_init.mode);
            check("init_dow",    int'(init_day_of_week_o),  m_init.dow);
            check("init_dom",    int'(init_day_of_month_o), m_init.dom);
            check("init_month",  int'(init_month_o),        m_init.mon);
            check("init_year",   int'(init_year_o),         m_init.year);
            if (enable_o) n_load++;
            if (err_o)    n_err++;
        end
    end

    // ---------------- stimulus ----------------
    // All drivers start and end at posedge+2.
    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input int n);
        wr_valid_i = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bit done = 1'b0;
        int guard = 0;
        while (!done) begin
            wr_valid_i = ($urandom_range(0, 2) != 0);
            wr_data_i  = wr_valid_i ? b : 8'($urandom);
            @(negedge clk_i);
            done = wr_valid_i && wr_ready_o;
            next_cycle();
            guard++;
            if (!done && guard > 100) begin
                miscompares++;
                $display("FAIL handshake_timeout at %0t: byte not accepted within 100 cycles", $time);
                done = 1'b1;
            end
        end
        wr_valid_i = 1'b0;
    endtask

    function automatic int fld(input rec_t r, input int i);
        case (i)
            0: return r.sec;  1: return r.min;  2: return r.hour; 3: return r.mode;
            4: return r.dow;  5: return r.dom;  6: return r.mon;
            7: return r.year % 256;
            default: return r.year / 256;
        endcase
    endfunction

    // Send the first n bytes of a record; junk sets the ignored upper bits randomly
    task automatic send_bytes(input rec_t r, input int n, input bit junk);
        logic [7:0] mask [9];
        logic [7:0] v;
        mask = '{8'h3F, 8'h3F, 8'h3F, 8'h03, 8'h07, 8'h1F, 8'h0F, 8'hFF, 8'h0F};
        for (int i = 0; i < n; i++) begin
            v = 8'(fld(r, i)) & mask[i];
            if (junk) v = v | (8'($urandom) & ~mask[i]);
            drive_byte(v);
        end
    endtask

    task automatic send_rec(input rec_t r);
        send_bytes(r, 9, 1'b1);
        idle(3);
    endtask

    task automatic do_abort();
        abort_i    = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = 8'($urandom);
        next_cycle();
        abort_i    = 1'b0;
        wr_valid_i = 1'b0;
    endtask

    function automatic rec_t mk(input int sec, min, hour, mode, dow, dom, mon, year);
        rec_t r;
        r.sec = sec; r.min = min; r.hour = hour; r.mode = mode;
        r.dow = dow; r.dom = dom; r.mon = mon; r.year = year;
        return r;
    endfunction

    initial begin
        int l0, e0, yr;
        rec_t r;
        #1 rst_i = 1'b1;
        chk_en = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        check("rst_year_lit", int'(init_year_o), 2000);
        check("rst_dow_lit",  int'(init_day_of_week_o), 1);
        check("rst_ready_lit", int'(wr_ready_o), 0);
        rst_i = 1'b0;
        #1 check("ready_after_release_lit", int'(wr_ready_o), 1);
        #1;
        next_cycle();

        // Valid 24h record: 23:45:30, 31 Dec 2023
        l0 = n_load;
        send_rec(mk(30, 45, 23, 0, 3, 31, 12, 2023));
        check("r1_loads_lit", n_load - l0, 1);
        check("r1_sec_lit",   int'(init_sec_o), 30);
        check("r1_min_lit",   int'(init_min_o), 45);
        check("r1_hour_lit",  int'(init_hour_o), 23);
        check("r1_dom_lit",   int'(init_day_of_month_o), 31);
        check("r1_year_lit",  int'(init_year_o), 2023);

        // Leap years
        l0 = n_load; e0 = n_err;
        send_rec(mk(0, 0, 0, 0, 4, 29, 2, 2024));
        check("leap2024_year_lit", int'(init_year_o), 2024);
        send_rec(mk(0, 0, 0, 0, 4, 29, 2, 2100));
        check("leap2100_year_lit", int'(init_year_o), 2024);
        send_rec(mk(0, 0, 0, 0, 4, 29, 2, 2000));
        check("leap2000_year_lit", int'(init_year_o), 2000);
        check("leap_loads_lit", n_load - l0, 2);
        check("leap_errs_lit",  n_err - e0, 1);

        // 12h mode
        l0 = n_load; e0 = n_err;
        send_rec(mk(5, 6, 12, 3, 7, 15, 6, 2030));
        check("h12_mode_lit", int'(init_mode_o), 3);
        send_rec(mk(5, 6, 0, 1, 7, 15, 6, 2030));
        send_rec(mk(5, 6, 10, 2, 7, 15, 6, 2030));
        check("h12_loads_lit", n_load - l0, 1);
        check("h12_errs_lit",  n_err - e0, 2);

        // Abort after 4 bytes, then a full record
        l0 = n_load;
        send_bytes(mk(11, 22, 9, 0, 1, 1, 1, 2001), 4, 1'b0);
        do_abort();
        send_rec(mk(44, 33, 17, 0, 5, 20, 8, 2025));
        check("abort_loads_lit", n_load - l0, 1);
        check("abort_min_lit",   int'(init_min_o), 33);
        check("abort_month_lit", int'(init_month_o), 8);

        // Reset after 5 bytes, then a fresh record
        send_bytes(mk(1, 2, 3, 0, 2, 10, 3, 2011), 5, 1'b0);
        rst_i = 1'b1;
        #1 check("midrst_sec_lit", int'(init_sec_o), 0);
        check("midrst_busy_lit", int'(busy_o), 0);
        #1;
        next_cycle();
        rst_i = 1'b0;
        l0 = n_load;
        send_rec(mk(59, 59, 11, 1, 6, 30, 11, 2099));
        check("postrst_loads_lit", n_load - l0, 1);
        check("postrst_hour_lit",  int'(init_hour_o), 11);

        // Randomized records, some aborted part-way
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0: yr = 2000; 1: yr = 2100; 2: yr = 2024;
                3: yr = 2023; default: yr = int'($urandom_range(0, 4095));
            endcase
            r = mk(int'($urandom_range(0, 62)), int'($urandom_range(0, 62)),
                   int'($urandom_range(0, 25)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 13)), yr);
            if ($urandom_range(0, 5) == 0) begin
                send_bytes(r, int'($urandom_range(1, 8)), 1'b1);
                do_abort();
            end
            send_rec(r);
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_preset_loader.md
TIME_PRESET_LOADER -- requirements
Module: time_preset_loader

Interface
REQ-001 The block SHALL be clocked by a single clock and reset by an asynchronous, active-high reset: clk_i  in  1  system clock; rst_i  in  1  async active-high reset.
REQ-002 The block SHALL have these handshake and control ports: wr_valid_i  in  1  byte offered; wr_data_i  in  8  record byte; wr_ready_o  out  1  byte accepted when high with wr_valid_i; abort_i  in  1  discard partial record.
REQ-003 The block SHALL have these time-counter load ports: enable_o  out  1  load strobe; en_preset_o  out  1  preset select.
REQ-004 The block SHALL have these time-counter preset value ports: init_sec_o  out  6; init_min_o  out  6; init_hour_o  out  6; init_mode_o  out  2  (bit0 = 12h, bit1 = PM).
REQ-005 The block SHALL have these calendar preset value ports: init_day_of_week_o  out  3; init_day_of_month_o  out  5; init_month_o  out  4; init_year_o  out  12.
REQ-006 The block SHALL have these status ports: busy_o  out  1  record in progress; err_o  out  1  one-cycle reject pulse.

Function
REQ-007 A record SHALL be exactly 9 bytes in this order: sec, min, hour, mode, dow, dom, month, year[7:0], year[11:8].
REQ-008 Each field SHALL take the low bits of its byte; upper bits are ignored, and validation SHALL apply to the truncated value.
REQ-009 The FSM SHALL have the states RECV, CHECK, LOAD and ERR, with RECV as the reset state.
REQ-010 In RECV, wr_ready_o SHALL be 1; a byte is accepted on a cycle with wr_valid_i=1 and wr_ready_o=1, stored in staging registers, and the byte index (0..8) advanced.
REQ-011 Accepting byte index 8 SHALL move the FSM to CHECK on the next edge; wr_ready_o SHALL be 0 in CHECK, LOAD and ERR.
REQ-012 CHECK SHALL last one cycle and go to LOAD if every field is valid, else to ERR.
REQ-013 Validity rule, time fields: sec <= 59; min <= 59.
REQ-014 Validity rule, hour and mode: if mode[0]=0, then hour <= 23 and mode[1]=0; if mode[0]=1, then 1 <= hour <= 12.
REQ-015 Validity rule, calendar fields: 1 <= dow <= 7; 1 <= month <= 12; 1 <= dom <= max_day.
REQ-016 max_day SHALL be 30 for months 4, 6, 9 and 11; for month 2 it SHALL be 29 when year[1:0]=0 and year != 2100, else 28; otherwise it SHALL be 31.
REQ-017 In LOAD (one cycle), enable_o and en_preset_o SHALL both be 1, and init_* SHALL already hold the new record on that cycle, having been updated from staging on the CHECK->LOAD edge.
REQ-018 Latency: if the last byte is accepted at edge N, the enable_o/en_preset_o pulse SHALL be high during cycle N+1..N+2, i.e. exactly one cycle, 2 edges after acceptance.
REQ-019 In ERR (one cycle), err_o SHALL be 1, init_* SHALL be unchanged, and enable_o and en_preset_o SHALL stay 0.
REQ-020 LOAD and ERR SHALL both return to RECV with the index at 0.
REQ-021 init_* SHALL change only on the CHECK->LOAD edge or on reset, and SHALL hold between loads.
REQ-022 busy_o SHALL be 1 when the index is nonzero or the FSM is in CHECK, LOAD or ERR.
REQ-023 abort_i=1 in RECV SHALL zero the index, and the staged bytes SHALL be discarded; a byte offered on the same cycle SHALL NOT be accepted (wr_ready_o=0 while abort_i=1).
REQ-024 abort_i SHALL be ignored in CHECK, LOAD and ERR.
REQ-025 enable_o and en_preset_o SHALL never be asserted separately, and SHALL never be asserted for more than one cycle per record.

Reset
REQ-026 While rst_i=1, and immediately on its assertion, the FSM SHALL be RECV with index 0, and wr_ready_o SHALL be 0.
REQ-027 While rst_i=1, enable_o, en_preset_o, err_o and busy_o SHALL be 0.
REQ-028 While rst_i=1, init_sec_o=0, init_min_o=0, init_hour_o=0 and init_mode_o=2'b00.
REQ-029 While rst_i=1, init_day_of_week_o=1, init_day_of_month_o=1, init_month_o=1 and init_year_o=2000.
REQ-030 Reset asserted mid-record SHALL discard all staged bytes; after release, wr_ready_o SHALL be 1 on the first cycle.

Verification
REQ-031 Valid 24h record: bytes 30,45,23,0,3,31,12,0xE7,0x07 -> one cycle with enable_o=en_preset_o=1, 2 edges after the last byte; init = 23:45:30, mode 00, dow 3, 31 Dec 2023.
REQ-032 Leap check: dom 29, month 2, year 2024 -> load; year 2100 -> err_o pulse and init_* unchanged; year 2000 -> load.
REQ-033 12h check: mode 0x03 with hour 12 -> load with init_mode_o=2'b11; mode 0x01 with hour 0 -> err_o; mode 0x02 (24h with PM set) -> err_o.
REQ-034 Handshake: wr_valid_i toggles randomly -> exactly 9 accepted bytes per record, wr_ready_o=0 during CHECK/LOAD/ERR, and no byte lost or duplicated.
REQ-035 Abort after 4 bytes, then a full valid record -> a single load carrying the second record's values.
REQ-036 rst_i pulsed after 5 bytes -> outputs at reset values, and the next 9 bytes form a fresh record that loads correctly.
